fetch_queue: RTL and testbench

Instruction fetch queue between the fetch stage and decode. Each cycle it accepts a fetch group of up to INSTR_PER_FETCH `fetch_entry_t` slots and compacts the valid slots into a circular buffer in program order. It presents one entry per cycle to decode through a valid/ready handshake. It also absorbs the rate mismatch between wide fetch and single-issue decode, and discards everything on a pipeline flush.

---
 rtl/tortoise_pkg.sv | 24 ++
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_compact.sv | 28 ++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 116 +++++++++++
 5 files changed

// File: rtl/tortoise_pkg.sv
// tortoise_pkg -- shared fetch-path types and sizing for the tortoise core front end.
// Revision 1.0
`default_nettype none

package tortoise_pkg;

   localparam int unsigned INSTR_PER_FETCH = 2;
   localparam int unsigned IFQ_DEPTH       = 8;

   typedef struct packed {
      logic        valid;
      logic        ex;
      logic [1:0]  predict;
      logic [31:0] addr;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef logic [$clog2(IFQ_DEPTH+1)-1:0]       ifq_cnt_t;
   typedef logic [$clog2(IFQ_DEPTH)-1:0]         ifq_ptr_t;
   typedef logic [$clog2(INSTR_PER_FETCH+1)-1:0] grp_cnt_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- fetch-side and decode-side handshake bundle of the fetch queue.
// Revision 1.0
`default_nettype none

interface fetch_queue_if;
   import tortoise_pkg::*;

   logic                                    fetch_valid_i;
   fetch_entry_t [INSTR_PER_FETCH-1:0]      fetch_entries_i;
   logic                                    fetch_ready_o;
   logic                                    decode_valid_o;
   fetch_entry_t                            decode_entry_o;
   logic                                    decode_ready_i;
   ifq_cnt_t                                count_o;

   modport master (
      output fetch_valid_i, fetch_entries_i, decode_ready_i,
      input  fetch_ready_o, decode_valid_o, decode_entry_o, count_o
   );

   modport slave (
      input  fetch_valid_i, fetch_entries_i, decode_ready_i,
      output fetch_ready_o, decode_valid_o, decode_entry_o, count_o
   );

endinterface

`default_nettype wire

// File: rtl/fetch_compact.sv
// fetch_compact -- prefix popcount of a fetch-group valid mask: slot write offsets and total count.
// Revision 1.0
`default_nettype none

module fetch_compact
   import tortoise_pkg::*;
(
   input  logic [INSTR_PER_FETCH-1:0] valid_mask,
   output grp_cnt_t                   n_valid,
   output ifq_ptr_t                   offset [INSTR_PER_FETCH]
);

   grp_cnt_t acc;

   always_comb begin
      acc    = '0;
      offset = '{default: '0};
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
         // a slot lands after every valid slot that precedes it
         offset[i] = ifq_ptr_t'(acc);
         acc       = acc + grp_cnt_t'(valid_mask[i]);
      end
      n_valid = acc;
   end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue -- compacts wide fetch groups into a circular buffer feeding single-issue decode.
// Revision 1.0
`default_nettype none

module fetch_queue
   import tortoise_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   fetch_queue_if.slave  bus
);

   localparam ifq_cnt_t READY_MAX = ifq_cnt_t'(IFQ_DEPTH - INSTR_PER_FETCH);

   fetch_entry_t                mem [IFQ_DEPTH];
   ifq_ptr_t                    rd_ptr;
   ifq_ptr_t                    wr_ptr;
   ifq_cnt_t                    cnt;

   logic [INSTR_PER_FETCH-1:0]  valid_mask;
   grp_cnt_t                    n_valid;
   ifq_ptr_t                    offset [INSTR_PER_FETCH];
   ifq_cnt_t                    n_push;
   logic                        fetch_ready;
   logic                        decode_valid;
   logic                        push;
   logic                        pop;
   fetch_entry_t                head;

   always_comb begin
      valid_mask = '0;
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
         valid_mask[i] = bus.fetch_entries_i[i].valid;
      end
   end

   fetch_compact u_compact (
      .valid_mask (valid_mask),
      .n_valid    (n_valid),
      .offset     (offset)
   );

   // ready looks only at the registered count, never at a same-cycle pop
   assign fetch_ready  = (cnt <= READY_MAX);
   assign decode_valid = (cnt != '0);
   assign push         = bus.fetch_valid_i && fetch_ready && !flush_i;
   assign pop          = decode_valid && bus.decode_ready_i && !flush_i;
   assign n_push       = push ? ifq_cnt_t'(n_valid) : '0;

   always_comb begin
      head       = mem[rd_ptr];
      head.valid = decode_valid;
   end

   assign bus.fetch_ready_o  = fetch_ready;
   assign bus.decode_valid_o = decode_valid;
   assign bus.decode_entry_o = head;
   assign bus.count_o        = cnt;

   always_ff @(posedge clk_i) begin
      if (push) begin
         for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            if (valid_mask[i]) begin
               mem[wr_ptr + offset[i]] <= bus.fetch_entries_i[i];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ifq_ptr_t'(n_valid);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ifq_ptr_t'(1);
         end
         cnt <= cnt + n_push - ifq_cnt_t'(pop);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- randomized scoreboard bench for fetch_queue against a queue-based reference.
// Revision 1.0
`default_nettype none

module tb_fetch_queue;
   import tortoise_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   fetch_queue_if bus ();

   fetch_queue dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   fetch_entry_t exp_q[$];
   logic         exp_ready  = 1'b1;
   logic         push_pend  = 1'b0;
   logic         flush_pend = 1'b0;
   int           vectors    = 0;
   int           miscompares = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compares DUT outputs against the reference and retires the head on a handshake.
   always @(negedge clk) begin
      check("count", 80'(bus.count_o), 80'(exp_q.size()));
      check("decode_valid", 80'(bus.decode_valid_o), 80'(exp_q.size() != 0));
      check("fetch_ready", 80'(bus.fetch_ready_o), 80'(exp_ready));
      if (bus.decode_valid_o && exp_q.size() != 0)
         check("head_entry", 80'(bus.decode_entry_o), 80'(exp_q[0]));
      if (rst_n && bus.decode_valid_o && bus.decode_ready_i && !flush && exp_q.size() != 0)
         void'(exp_q.pop_front());
   end

   // Apply the edge just taken to the reference, then drive a fresh random cycle.
   task automatic step(input int p_valid, input int p_ready, input int p_flush);
      fetch_entry_t e;
      @(posedge clk);
      #1;
      if (flush_pend) begin
         exp_q.delete();
      end else if (push_pend) begin
         for (int i = 0; i < INSTR_PER_FETCH; i++)
            if (bus.fetch_entries_i[i].valid) exp_q.push_back(bus.fetch_entries_i[i]);
      end
      exp_ready = (IFQ_DEPTH - exp_q.size()) >= INSTR_PER_FETCH;

      bus.fetch_valid_i = ($urandom_range(99) < p_valid);
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
         e.valid   = ($urandom_range(3) != 0);
         e.ex      = 1'($urandom_range(1));
         e.predict = 2'($urandom_range(3));
         e.addr    = $urandom;
         e.instr   = $urandom;
         bus.fetch_entries_i[i] = e;
      end
      bus.decode_ready_i = ($urandom_range(99) < p_ready);
      flush              = ($urandom_range(99) < p_flush);
      push_pend  = bus.fetch_valid_i && exp_ready && !flush;
      flush_pend = flush;
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #1;
      rst_n              = 1'b0;
      exp_q.delete();
      exp_ready          = 1'b1;
      push_pend          = 1'b0;
      flush_pend         = 1'b0;
      flush              = 1'b0;
      bus.fetch_valid_i  = 1'b0;
      bus.decode_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.fetch_valid_i   = 1'b0;
      bus.fetch_entries_i = '0;
      bus.decode_ready_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4)   step(0, 0, 0);
      repeat (300) step(90, 90, 2);
      repeat (20)  step(100, 0, 0);
      repeat (20)  step(0, 100, 0);
      repeat (300) step(90, 10, 1);
      repeat (200) step(30, 95, 0);
      mid_reset();
      repeat (300) step(100, 50, 5);
      repeat (30)  step(0, 100, 0);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
